// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon output framing path.
package ascon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    CAPTURE,
    EMIT,
    DONE
  } state_t;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  // Header byte, then payload bytes, then tag bytes.
  function automatic int unsigned frame_len(input int unsigned y_bits,
                                            input int unsigned t_bits);
    return 1 + y_bits / 8 + t_bits / 8;
  endfunction

endpackage

// File: rtl/ascon_sipo.sv
// LSB-first serial-in/parallel-out register with byte read-out by index.
module ascon_sipo #(
  parameter int unsigned W = 32,
  localparam int unsigned NB = W / 8,
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          bit_in,
  input  logic [IW-1:0] sel,
  output logic [7:0]    byte_out
);

  logic [W-1:0] sr;

  // Shift right so that after W enabled cycles the first bit sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (en) begin
      sr <= {bit_in, sr[W-1:1]};
    end
  end

  // Select byte sel, i.e. sr[8*sel+7:8*sel].
  always_comb begin
    byte_out = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (sel == IW'(i)) begin
        byte_out = sr[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ascon_out_framer.sv
// Deserialises the core's payload/tag bit streams and emits a header+payload+tag
// byte frame on a valid/ready stream.
module ascon_out_framer
  import ascon_pkg::*;
#(
  parameter int unsigned y   = 32,
  parameter int unsigned t   = 128,
  parameter logic [7:0]  HDR = HDR_BASE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       encryption_readyxSI,
  input  logic       cipher_textxSI,
  input  logic       tagxSI,
  input  logic       decryption_readyxSI,
  input  logic       plain_textxSI,
  input  logic       dec_tagxSI,
  input  logic       message_authenticationxSI,
  output logic [7:0] out_dataxSO,
  output logic       out_validxSO,
  input  logic       out_readyxSI,
  output logic       out_lastxSO,
  output logic       abortxSO,
  output logic       busyxSO
);

  localparam int unsigned MAXL = (y > t) ? y : t;
  localparam int unsigned CW   = $clog2(MAXL);
  localparam int unsigned FLEN = frame_len(y, t);
  localparam int unsigned BW   = $clog2(FLEN + 1);
  localparam int unsigned PNB  = y / 8;
  localparam int unsigned TNB  = t / 8;
  localparam int unsigned PIW  = (PNB > 1) ? $clog2(PNB) : 1;
  localparam int unsigned TIW  = (TNB > 1) ? $clog2(TNB) : 1;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [BW-1:0]  bidx, bidx_n;
  logic           mode, mode_n;
  logic           auth, auth_n;
  logic           enc_q, dec_q;
  logic [7:0]     data_n;
  logic           valid_n, last_n, abort_n;

  logic           enc_rise, dec_rise, sel_ready;
  logic           pay_en, tag_en, pay_bit, tag_bit;
  logic [PIW-1:0] pay_sel;
  logic [TIW-1:0] tag_sel;
  logic [7:0]     pay_byte, tag_byte, next_byte;

  assign enc_rise  = encryption_readyxSI & ~enc_q;
  assign dec_rise  = decryption_readyxSI & ~dec_q;
  assign sel_ready = (mode == MODE_ENC) ? encryption_readyxSI : decryption_readyxSI;
  assign pay_bit   = (mode == MODE_ENC) ? cipher_textxSI : plain_textxSI;
  assign tag_bit   = (mode == MODE_ENC) ? tagxSI : dec_tagxSI;
  assign busyxSO   = (state != IDLE);

  ascon_sipo #(.W(y)) u_payload (
    .clk      (clk),
    .rst      (rst),
    .en       (pay_en),
    .bit_in   (pay_bit),
    .sel      (pay_sel),
    .byte_out (pay_byte)
  );

  ascon_sipo #(.W(t)) u_tag (
    .clk      (clk),
    .rst      (rst),
    .en       (tag_en),
    .bit_in   (tag_bit),
    .sel      (tag_sel),
    .byte_out (tag_byte)
  );

  // Byte bidx of the frame: header, then payload bytes, then tag bytes.
  always_comb begin
    pay_sel = PIW'(bidx - BW'(1));
    tag_sel = TIW'(bidx - BW'(1 + PNB));
    if (bidx == '0) begin
      next_byte = HDR | {6'b0, mode, auth};
    end else if (bidx <= BW'(PNB)) begin
      next_byte = pay_byte;
    end else begin
      next_byte = tag_byte;
    end
  end

  // Next-state, capture enables and output-register updates.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    mode_n  = mode;
    auth_n  = auth;
    data_n  = out_dataxSO;
    valid_n = out_validxSO;
    last_n  = out_lastxSO;
    abort_n = 1'b0;
    pay_en  = 1'b0;
    tag_en  = 1'b0;
    case (state)
      IDLE: begin
        if (enc_rise || dec_rise) begin
          state_n = ALIGN;
          mode_n  = enc_rise ? MODE_ENC : MODE_DEC;
        end
      end
      ALIGN: begin
        if (!sel_ready) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end
      end
      CAPTURE: begin
        if (!sel_ready) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else begin
          pay_en = (32'(cnt) < y);
          tag_en = (32'(cnt) < t);
          if (cnt == '0) begin
            auth_n = (mode == MODE_ENC) ? 1'b1 : message_authenticationxSI;
          end
          if (cnt == CW'(MAXL - 1)) begin
            state_n = EMIT;
            bidx_n  = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      EMIT: begin
        // Load the next byte whenever the output slot is empty or being drained,
        // giving one byte per clock under continuous ready.
        if (out_validxSO && out_readyxSI && out_lastxSO) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          state_n = DONE;
        end else if (!out_validxSO || out_readyxSI) begin
          data_n  = next_byte;
          last_n  = (bidx == BW'(FLEN - 1));
          valid_n = 1'b1;
          bidx_n  = bidx + BW'(1);
        end
      end
      DONE: begin
        if (!encryption_readyxSI && !decryption_readyxSI) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bidx         <= '0;
      mode         <= MODE_DEC;
      auth         <= 1'b0;
      enc_q        <= 1'b0;
      dec_q        <= 1'b0;
      out_dataxSO  <= '0;
      out_validxSO <= 1'b0;
      out_lastxSO  <= 1'b0;
      abortxSO     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bidx         <= bidx_n;
      mode         <= mode_n;
      auth         <= auth_n;
      enc_q        <= encryption_readyxSI;
      dec_q        <= decryption_readyxSI;
      out_dataxSO  <= data_n;
      out_validxSO <= valid_n;
      out_lastxSO  <= last_n;
      abortxSO     <= abort_n;
    end
  end

endmodule

// File: tb/tb_ascon_out_framer.sv
// Scoreboard bench for ascon_out_framer: stimulus pushes expected frame bytes,
// a monitor pops and compares each transferred byte.
module tb_ascon_out_framer;

  localparam int unsigned Y    = 32;
  localparam int unsigned T    = 128;
  localparam int unsigned MAXL = 128;
  localparam int unsigned FLEN = 21;

  logic       clk, rst;
  logic       enc_r, ct, tg, dec_r, pt, dtg, mauth;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last, abort_o, busy_o;

  ascon_out_framer #(.y(Y), .t(T), .HDR(8'hA0)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .encryption_readyxSI       (enc_r),
    .cipher_textxSI            (ct),
    .tagxSI                    (tg),
    .decryption_readyxSI       (dec_r),
    .plain_textxSI             (pt),
    .dec_tagxSI                (dtg),
    .message_authenticationxSI (mauth),
    .out_dataxSO               (out_data),
    .out_validxSO              (out_valid),
    .out_readyxSI              (out_ready),
    .out_lastxSO               (out_last),
    .abortxSO                  (abort_o),
    .busyxSO                   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;
  logic [8:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header from mode/auth, then bytes by shifting the words.
  task automatic push_frame(input bit enc_mode, input bit auth,
                            input logic [Y-1:0] pay, input logic [T-1:0] tag);
    logic [7:0] hdr;
    hdr = 8'hA0 + (enc_mode ? 8'd2 : 8'd0) + ((enc_mode || auth) ? 8'd1 : 8'd0);
    sb.push_back({1'b0, hdr});
    for (int n = 0; n < int'(Y / 8); n++)
      sb.push_back({1'b0, 8'((pay >> (8 * n)) & 255)});
    for (int n = 0; n < int'(T / 8); n++)
      sb.push_back({(n == int'(T / 8) - 1), 8'((tag >> (8 * n)) & 255)});
  endtask

  // Consumer ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random.
  always @(negedge clk) begin
    case (rdy_mode)
      1: begin
        out_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: every transfer pops one expected byte; stalls must hold data.
  logic       held_v = 1'b0;
  logic [8:0] held;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({out_last, out_data}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", {out_last, out_data});
        end else begin
          chk("byte", 32'({out_last, out_data}), 32'(sb.pop_front()));
        end
        xfers++;
      end
      held_v = out_valid && !out_ready;
      held   = {out_last, out_data};
    end
  end

  // Raise ready(s), walk align + capture, optionally drop ready at abort_at.
  task automatic drive_frame(input bit e, input bit d, input bit auth,
                             input logic [Y-1:0] pay, input logic [T-1:0] tag,
                             input int abort_at);
    bit m;
    m = e;
    if (abort_at < 0) push_frame(m, auth, pay, tag);
    enc_r = e;
    dec_r = d;
    mauth = auth;
    @(negedge clk);
    chk("busy_align", 32'(busy_o), 32'd1);
    @(negedge clk);
    for (int c = 0; c < int'(MAXL); c++) begin
      ct  = (m && c < int'(Y)) ? pay[c] : 1'($urandom);
      pt  = (!m && c < int'(Y)) ? pay[c] : 1'($urandom);
      tg  = (m && c < int'(T)) ? tag[c] : 1'($urandom);
      dtg = (!m && c < int'(T)) ? tag[c] : 1'($urandom);
      if (c > 0) mauth = 1'($urandom);
      if (c == abort_at) begin
        enc_r = 1'b0;
        dec_r = 1'b0;
        @(negedge clk);
        chk("abort_pulse", 32'(abort_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("abort_clear", 32'(abort_o), 32'd0);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic finish_frame();
    wait_drain();
    @(negedge clk);
    chk("valid_after_last", 32'(out_valid), 32'd0);
    chk("busy_done", 32'(busy_o), 32'd1);
    enc_r = 1'b0;
    dec_r = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    rst = 1'b1;
    {enc_r, ct, tg, dec_r, pt, dtg, mauth} = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_abort", 32'(abort_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;

    // Encryption frame with fixed vectors.
    start = xfers;
    drive_frame(1, 0, 0, 32'h89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF, -1);
    finish_frame();
    chk("enc_count", 32'(xfers - start), FLEN);

    // Decryption with failed authentication.
    drive_frame(0, 1, 0, 32'h01020304, {$urandom, $urandom, $urandom, $urandom}, -1);
    finish_frame();

    // Backpressure pattern 1,0,0,...
    rdy_mode = 1;
    start = xfers;
    drive_frame(1, 0, 1, $urandom, {$urandom, $urandom, $urandom, $urandom}, -1);
    finish_frame();
    chk("bp_count", 32'(xfers - start), FLEN);
    rdy_mode = 0;

    // Abort mid-capture, then a clean frame.
    drive_frame(1, 0, 1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 10);
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", 32'(out_valid), 32'd0);
    end
    drive_frame(0, 1, 1, $urandom, {$urandom, $urandom, $urandom, $urandom}, -1);
    finish_frame();

    // Simultaneous rise: encryption wins; DONE holds while either ready is high.
    drive_frame(1, 1, 0, $urandom, {$urandom, $urandom, $urandom, $urandom}, -1);
    wait_drain();
    repeat (5) begin
      @(negedge clk);
      chk("done_hold_valid", 32'(out_valid), 32'd0);
      chk("done_hold_busy", 32'(busy_o), 32'd1);
    end
    enc_r = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_one_high", 32'(busy_o), 32'd1);
    end
    dec_r = 1'b0;
    @(negedge clk);
    chk("done_release", 32'(busy_o), 32'd0);

    // Reset during emit after the fifth byte.
    start = xfers;
    drive_frame(1, 0, 1, $urandom, {$urandom, $urandom, $urandom, $urandom}, -1);
    n = 0;
    while (xfers < start + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_emit_reach", 32'(xfers - start), 32'd5);
    rst = 1'b1;
    enc_r = 1'b0;
    @(negedge clk);
    chk("rst_emit_valid", 32'(out_valid), 32'd0);
    chk("rst_emit_data", 32'(out_data), 32'd0);
    chk("rst_emit_last", 32'(out_last), 32'd0);
    chk("rst_emit_busy", 32'(busy_o), 32'd0);
    sb.delete();
    rst = 1'b0;
    @(negedge clk);

    // Random frames under random backpressure.
    rdy_mode = 2;
    for (int k = 0; k < 5; k++) begin
      bit e;
      e = 1'($urandom);
      start = xfers;
      drive_frame(e, !e, 1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom}, -1);
      finish_frame();
      chk("rand_count", 32'(xfers - start), FLEN);
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_out_framer.md
Name: ascon_out_framer

Overview:
Downstream stage of the masked Ascon top. Deserialises the 1-bit-per-clock ciphertext/plaintext and tag streams the core shifts out after encryption_readyxSO / decryption_readyxSO. Assembles them into a byte frame and presents it on a valid/ready byte stream to the host interface. It also carries the mode and authentication result in a header byte.

Parameters:
y, 32, payload length in bits (ciphertext or plaintext); must be ≥8, multiple of 8
t, 128, tag length in bits
HDR, 8'hA0, header base value; low 2 bits carry {mode, auth}

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
encryption_readyxSI  input  1  core encryption-ready level
cipher_textxSI  input  1  serial ciphertext bit, LSB first
tagxSI  input  1  serial encryption tag bit, LSB first
decryption_readyxSI  input  1  core decryption-ready level
plain_textxSI  input  1  serial decrypted (or random-substitute) plaintext bit, LSB first
dec_tagxSI  input  1  serial decryption tag bit, LSB first
message_authenticationxSI  input  1  core authentication result, valid while decryption_readyxSI high
out_dataxSO  output  8  frame byte
out_validxSO  output  1  byte valid
out_readyxSI  input  1  consumer accepts byte
out_lastxSO  output  1  final byte of frame (qualified by out_validxSO)
abortxSO  output  1  one-cycle pulse: ready dropped mid-capture
busyxSO  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, bit counter 0, byte counter 0, payload/tag shift registers 0; out_dataxSO=0, out_validxSO=0, out_lastxSO=0, abortxSO=0, busyxSO=0. Reset wins over all other events, including mid-capture and mid-emit.
- States: IDLE → ALIGN → CAPTURE → EMIT → DONE → IDLE.
- IDLE:
  - A rising edge of encryption_readyxSI or decryption_readyxSI (level high now, low last cycle) moves to ALIGN.
  - Mode is latched as enc=1 / dec=0. If both rise in the same cycle, encryption wins.
- ALIGN: exactly 1 cycle. It absorbs the core's registered output, since bit 0 appears the cycle after ready rises.
- CAPTURE:
  - Runs for max(y,t) cycles; counter c runs 0..max(y,t)-1.
  - At count c, payload bit c is taken from cipher_textxSI (enc) or plain_textxSI (dec) if c<y. Tag bit c is taken from tagxSI / dec_tagxSI if c<t. Bits beyond each length are ignored.
  - Auth flag is sampled at c=0: forced 1 in enc mode, else message_authenticationxSI.
  - If the selected ready falls during ALIGN or CAPTURE: abortxSO pulses one cycle, state returns to IDLE, and no bytes are emitted.
- EMIT:
  - Frame = 1 header byte, then y/8 payload bytes, then t/8 tag bytes. Total 21 bytes at defaults.
  - Header = HDR | {6'b0, mode, auth}: enc 0xA3, dec-pass 0xA1, dec-fail 0xA0.
  - Payload byte n = payload[8n+7:8n], n ascending; tag bytes follow the same order.
  - out_validxSO rises the cycle after entering EMIT.
  - A byte transfers on a cycle with out_validxSO && out_readyxSI. The next byte is presented the following cycle with no bubble, so back-to-back transfers give 1 byte/clk.
  - While out_validxSO && !out_readyxSI, out_dataxSO and out_lastxSO are held stable.
  - out_lastxSO is high only with the final tag byte. After that transfer, out_validxSO drops and the state goes to DONE.
  - Dropping ready during EMIT has no effect; the frame completes.
- DONE: waits until both ready inputs are low, then returns to IDLE. Only a fresh rising edge starts a new frame, because the core holds ready high.
- abortxSO is 0 outside the abort cycle. busyxSO = (state != IDLE).

Decomposition:
- Shared package ascon_pkg:
  - state encoding constants (IDLE, ALIGN, CAPTURE, EMIT, DONE)
  - HDR value
  - MODE_ENC/MODE_DEC constants
  - frame-length function (1 + y/8 + t/8)
- One natural sub-module, ascon_sipo, instantiated twice (payload and tag). It is an LSB-first serial-in/parallel-out register with enable and width parameter, plus byte-select read by index.
- Framer FSM, header mux and handshake stay in ascon_out_framer.

Test Plan:
- Enc frame: rise encryption_readyxSI; after 1 align cycle feed ct=32'h89ABCDEF and tag=128'h00112233_44556677_8899AABB_CCDDEEFF LSB first; out_readyxSI=1 → 21 bytes A3,EF,CD,AB,89,FF,EE,…,00; out_lastxSO high only on the 21st byte.
- Dec fail: decryption_readyxSI rises with message_authenticationxSI=0, pt=32'h01020304 → header 0xA0, then 04,03,02,01, then 16 tag bytes.
- Backpressure: out_readyxSI toggles 1,0,0,1,… → no byte lost or duplicated; data stable during every stall; still 21 transfers.
- Abort: drop encryption_readyxSI at capture cycle 10 → abortxSO one-cycle pulse, no out_validxSO, busyxSO=0 the next cycle; a new rising edge yields a correct frame.
- Simultaneous rise of both readys → encryption mode, header 0xA3; DONE holds until both readys are low; no second frame while they stay high.
- Assert rst during EMIT after byte 5 → next cycle out_validxSO=0, all outputs 0, state IDLE.
